// File: rtl/ctrl_pkg.sv
// Shared constants for the Mini SRC control sequencer: opcodes, FSM state
// encoding, instruction classes and small decode helpers.
package ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // T3..T7 must stay contiguous: execute steps advance by incrementing.
  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP, CL_HALT, CL_ALU_REG, CL_ALU_IMM, CL_NEGNOT, CL_MULDIV, CL_LDI,
    CL_LD, CL_ST, CL_BR, CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO
  } iclass_t;

  // Final execute state of each class; the state after it is T0.
  function automatic state_t last_state(input iclass_t c);
    case (c)
      CL_NEGNOT, CL_JAL:                 last_state = S_T4;
      CL_ALU_REG, CL_ALU_IMM, CL_LDI:    last_state = S_T5;
      CL_MULDIV, CL_BR:                  last_state = S_T6;
      CL_LD, CL_ST:                      last_state = S_T7;
      default:                           last_state = S_T3;
    endcase
  endfunction

  // Immediate forms reuse the register-form ALU operation.
  function automatic logic [4:0] alu_sel(input logic [4:0] op);
    case (op)
      OP_ADDI: alu_sel = OP_ADD;
      OP_ANDI: alu_sel = OP_AND;
      OP_ORI:  alu_sel = OP_OR;
      default: alu_sel = op;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath strobe bundle. Every strobe is a Moore output,
// held for the whole state and sampled by the datapath at the closing rising
// edge; IR and con_ff flow back from the datapath. dbg_state exposes the FSM.
interface control_unit_if import ctrl_pkg::*; #(
  parameter int IR_W = 32,
  parameter int OP_W = 5
) ();
  logic [IR_W-1:0] IR;
  logic            con_ff;
  logic PC_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, In_port_out;
  logic MDR_out, BA_out, R_out;
  logic PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable, Z_enable;
  logic HI_enable, LO_enable, R_in, out_port_enable, con_in;
  logic Gra, Grb, Grc, IncPC, Read, RAM_write_enable;
  logic [OP_W-1:0] opcode;
  logic            run;
  state_t          dbg_state;

  modport master (
    input  IR, con_ff,
    output PC_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, In_port_out,
           MDR_out, BA_out, R_out, PC_enable, IR_enable, MAR_enable,
           MDR_enable, Y_enable, Z_enable, HI_enable, LO_enable, R_in,
           out_port_enable, con_in, Gra, Grb, Grc, IncPC, Read,
           RAM_write_enable, opcode, run, dbg_state
  );

  modport slave (
    output IR, con_ff,
    input  PC_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, In_port_out,
           MDR_out, BA_out, R_out, PC_enable, IR_enable, MAR_enable,
           MDR_enable, Y_enable, Z_enable, HI_enable, LO_enable, R_in,
           out_port_enable, con_in, Gra, Grb, Grc, IncPC, Read,
           RAM_write_enable, opcode, run, dbg_state
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode -> instruction class. mul/div only form their own
// class when CTRL_MULDIV_EN is defined; otherwise they behave as nop.
module ctrl_decode import ctrl_pkg::*; (
  input  logic [4:0] i_op,
  output iclass_t    o_class
);

  // Map each opcode onto the execute sequence it uses
  always_comb begin
    o_class = CL_NOP;
    case (i_op)
      OP_LD:   o_class = CL_LD;
      OP_LDI:  o_class = CL_LDI;
      OP_ST:   o_class = CL_ST;
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR:
               o_class = CL_ALU_REG;
      OP_ADDI, OP_ANDI, OP_ORI:
               o_class = CL_ALU_IMM;
`ifdef CTRL_MULDIV_EN
      OP_MUL, OP_DIV: o_class = CL_MULDIV;
`else
      OP_MUL, OP_DIV: o_class = CL_NOP;
`endif
      OP_NEG, OP_NOT: o_class = CL_NEGNOT;
      OP_BR:   o_class = CL_BR;
      OP_JR:   o_class = CL_JR;
      OP_JAL:  o_class = CL_JAL;
      OP_IN:   o_class = CL_IN;
      OP_OUT:  o_class = CL_OUT;
      OP_MFHI: o_class = CL_MFHI;
      OP_MFLO: o_class = CL_MFLO;
      OP_HALT: o_class = CL_HALT;
      default: o_class = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer: fetch T0-T2, per-class execute T3-T7.
// Optional macro CTRL_MULDIV_EN enables the mul/div execute sequence.
module control_unit import ctrl_pkg::*; #(
  parameter int IR_W = 32,
  parameter int OP_W = 5
) (
  input  logic           clk,
  input  logic           clr,
  control_unit_if.master bus
);

  state_t          r_state, w_next;
  iclass_t         r_class, w_dec_class;
  logic [OP_W-1:0] w_op, w_alu_op;
  logic            w_unused_ir;

  assign w_op        = bus.IR[IR_W-1 -: OP_W];
  assign w_alu_op    = alu_sel(w_op);
  assign w_unused_ir = ^bus.IR[IR_W-OP_W-1:0];
  assign bus.dbg_state = r_state;

  ctrl_decode u_decode (.i_op(w_op), .o_class(w_dec_class));

  // State register; class is latched on the T2->T3 edge and held through execute
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_RESET;
      r_class <= CL_NOP;
    end else begin
      r_state <= w_next;
      if (r_state == S_T2) r_class <= w_dec_class;
    end
  end

  // Next state: fetch is fixed; T2 branches on the decoded opcode (nop/halt
  // skip execute); execute steps advance until the class's final state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = S_T2;
      S_T2: begin
        if (w_dec_class == CL_NOP)       w_next = S_T0;
        else if (w_dec_class == CL_HALT) w_next = S_HALT;
        else                             w_next = S_T3;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = (r_state == last_state(r_class)) ? S_T0
                                                         : state_t'(r_state + 4'd1);
    endcase
  end

  // Moore strobe decode from state plus latched class; everything defaults to 0
  always_comb begin
    bus.PC_out = 1'b0;    bus.ZLow_out = 1'b0;   bus.ZHigh_out = 1'b0;
    bus.HI_out = 1'b0;    bus.LO_out = 1'b0;     bus.C_out = 1'b0;
    bus.In_port_out = 1'b0; bus.MDR_out = 1'b0;  bus.BA_out = 1'b0;
    bus.R_out = 1'b0;     bus.PC_enable = 1'b0;  bus.IR_enable = 1'b0;
    bus.MAR_enable = 1'b0; bus.MDR_enable = 1'b0; bus.Y_enable = 1'b0;
    bus.Z_enable = 1'b0;  bus.HI_enable = 1'b0;  bus.LO_enable = 1'b0;
    bus.R_in = 1'b0;      bus.out_port_enable = 1'b0; bus.con_in = 1'b0;
    bus.Gra = 1'b0;       bus.Grb = 1'b0;        bus.Grc = 1'b0;
    bus.IncPC = 1'b0;     bus.Read = 1'b0;       bus.RAM_write_enable = 1'b0;
    bus.opcode = '0;      bus.run = 1'b0;
    case (r_state)
      S_T0: begin
        bus.run = 1'b1; bus.PC_out = 1'b1; bus.MAR_enable = 1'b1;
        bus.IncPC = 1'b1; bus.Z_enable = 1'b1;
      end
      S_T1: begin
        bus.run = 1'b1; bus.ZLow_out = 1'b1; bus.PC_enable = 1'b1;
        bus.Read = 1'b1; bus.MDR_enable = 1'b1;
      end
      S_T2: begin
        bus.run = 1'b1; bus.MDR_out = 1'b1; bus.IR_enable = 1'b1;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        bus.run    = 1'b1;
        bus.opcode = w_alu_op;
        case (r_class)
          CL_ALU_REG, CL_ALU_IMM: begin
            if (r_state == S_T3) begin
              bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1;
            end else if (r_state == S_T4) begin
              bus.Z_enable = 1'b1;
              if (r_class == CL_ALU_IMM) bus.C_out = 1'b1;
              else begin bus.Grc = 1'b1; bus.R_out = 1'b1; end
            end else if (r_state == S_T5) begin
              bus.ZLow_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1;
            end
          end
          CL_NEGNOT: begin
            if (r_state == S_T3) begin
              bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Z_enable = 1'b1;
            end else if (r_state == S_T4) begin
              bus.ZLow_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1;
            end
          end
          CL_MULDIV: begin
            if (r_state == S_T3) begin
              bus.Gra = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1;
            end else if (r_state == S_T4) begin
              bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Z_enable = 1'b1;
            end else if (r_state == S_T5) begin
              bus.ZLow_out = 1'b1; bus.LO_enable = 1'b1;
            end else if (r_state == S_T6) begin
              bus.ZHigh_out = 1'b1; bus.HI_enable = 1'b1;
            end
          end
          CL_LDI, CL_LD, CL_ST: begin
            if (r_state == S_T3) begin
              bus.Grb = 1'b1; bus.BA_out = 1'b1; bus.Y_enable = 1'b1;
            end else if (r_state == S_T4) begin
              bus.C_out = 1'b1; bus.Z_enable = 1'b1; bus.opcode = OP_ADD;
            end else if (r_state == S_T5) begin
              bus.ZLow_out = 1'b1;
              if (r_class == CL_LDI) begin bus.Gra = 1'b1; bus.R_in = 1'b1; end
              else bus.MAR_enable = 1'b1;
            end else if (r_state == S_T6) begin
              bus.MDR_enable = 1'b1;
              if (r_class == CL_LD) bus.Read = 1'b1;
              else begin bus.Gra = 1'b1; bus.R_out = 1'b1; end
            end else if (r_state == S_T7) begin
              if (r_class == CL_LD) begin
                bus.MDR_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1;
              end else bus.RAM_write_enable = 1'b1;
            end
          end
          CL_BR: begin
            if (r_state == S_T3) begin
              bus.Gra = 1'b1; bus.R_out = 1'b1; bus.con_in = 1'b1;
            end else if (r_state == S_T4) begin
              bus.PC_out = 1'b1; bus.Y_enable = 1'b1;
            end else if (r_state == S_T5) begin
              bus.C_out = 1'b1; bus.Z_enable = 1'b1; bus.opcode = OP_ADD;
            end else if (r_state == S_T6) begin
              bus.ZLow_out = 1'b1; bus.PC_enable = bus.con_ff;
            end
          end
          CL_JR:  begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.PC_enable = 1'b1; end
          CL_JAL: begin
            if (r_state == S_T3) begin
              bus.PC_out = 1'b1; bus.Grb = 1'b1; bus.R_in = 1'b1;
            end else if (r_state == S_T4) begin
              bus.Gra = 1'b1; bus.R_out = 1'b1; bus.PC_enable = 1'b1;
            end
          end
          CL_IN:   begin bus.In_port_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
          CL_OUT:  begin bus.Gra = 1'b1; bus.R_out = 1'b1; bus.out_port_enable = 1'b1; end
          CL_MFHI: begin bus.HI_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
          CL_MFLO: begin bus.LO_out = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
`ifdef CTRL_MULDIV_EN
    // HI/LO loads come from the mul/div sequence above
`else
    bus.HI_enable = 1'b0;
    bus.LO_enable = 1'b0;
`endif
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected strobe sequences built
// from the instruction tables, checked every cycle by one compare process.
module tb_control_unit;
  localparam int W = 33;
  localparam int N = 20;

  // Vector layout: [32:28] opcode, [27] run, [26:0] strobes
  localparam logic [W-1:0] PC_O   = 33'd1 << 0;
  localparam logic [W-1:0] ZLO_O  = 33'd1 << 1;
  localparam logic [W-1:0] ZHI_O  = 33'd1 << 2;
  localparam logic [W-1:0] HI_O   = 33'd1 << 3;
  localparam logic [W-1:0] LO_O   = 33'd1 << 4;
  localparam logic [W-1:0] C_O    = 33'd1 << 5;
  localparam logic [W-1:0] INP_O  = 33'd1 << 6;
  localparam logic [W-1:0] MDR_O  = 33'd1 << 7;
  localparam logic [W-1:0] BA_O   = 33'd1 << 8;
  localparam logic [W-1:0] R_O    = 33'd1 << 9;
  localparam logic [W-1:0] PC_E   = 33'd1 << 10;
  localparam logic [W-1:0] IR_E   = 33'd1 << 11;
  localparam logic [W-1:0] MAR_E  = 33'd1 << 12;
  localparam logic [W-1:0] MDR_E  = 33'd1 << 13;
  localparam logic [W-1:0] Y_E    = 33'd1 << 14;
  localparam logic [W-1:0] Z_E    = 33'd1 << 15;
  localparam logic [W-1:0] HI_E   = 33'd1 << 16;
  localparam logic [W-1:0] LO_E   = 33'd1 << 17;
  localparam logic [W-1:0] R_IN   = 33'd1 << 18;
  localparam logic [W-1:0] OUTP_E = 33'd1 << 19;
  localparam logic [W-1:0] CON_IN = 33'd1 << 20;
  localparam logic [W-1:0] GRA    = 33'd1 << 21;
  localparam logic [W-1:0] GRB    = 33'd1 << 22;
  localparam logic [W-1:0] GRC    = 33'd1 << 23;
  localparam logic [W-1:0] INCPC  = 33'd1 << 24;
  localparam logic [W-1:0] READ   = 33'd1 << 25;
  localparam logic [W-1:0] RAMW   = 33'd1 << 26;
  localparam logic [W-1:0] RUN    = 33'd1 << 27;

`ifdef CTRL_MULDIV_EN
  localparam int MUL_LEN = 7;
`else
  localparam int MUL_LEN = 3;
`endif

  // Directed table: add, out, br x2, ld, st, ldi, addi, ori, neg, not, jr,
  // jal, in, mfhi, mflo, shr, mul, nop, undefined
  logic [31:0] t_ir [N] = '{32'h19890000, 32'hB8800000, 32'h98000000,
    32'h98000000, 32'h00800000, 32'h11000000, 32'h08000000, 32'h60000000,
    32'h70000000, 32'h88000000, 32'h90000000, 32'hA0000000, 32'hA8000000,
    32'hB0000000, 32'hC0000000, 32'hC8000000, 32'h28000000, 32'h78000000,
    32'hD0000000, 32'hE0000000};
  logic        t_cf [N] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                            0, 0, 0, 0};
  int          t_len [N] = '{6, 4, 7, 7, 8, 8, 6, 6, 6, 5, 5, 4, 5, 4, 4, 4,
                             6, MUL_LEN, 3, 3};

  // clock / reset
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  control_unit_if #(.IR_W(32), .OP_W(5)) bus ();
  control_unit #(.IR_W(32), .OP_W(5)) dut (.clk(clk), .clr(clr), .bus(bus));

  logic [W-1:0] w_act;
  assign w_act = {bus.opcode, bus.run, bus.RAM_write_enable, bus.Read,
                  bus.IncPC, bus.Grc, bus.Grb, bus.Gra, bus.con_in,
                  bus.out_port_enable, bus.R_in, bus.LO_enable, bus.HI_enable,
                  bus.Z_enable, bus.Y_enable, bus.MDR_enable, bus.MAR_enable,
                  bus.IR_enable, bus.PC_enable, bus.R_out, bus.BA_out,
                  bus.MDR_out, bus.In_port_out, bus.C_out, bus.LO_out,
                  bus.HI_out, bus.ZHigh_out, bus.ZLow_out, bus.PC_out};

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] seq_q[$];
  int           t0_q[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;

  function automatic logic [W-1:0] opf(input logic [4:0] o);
    opf = {o, 28'd0};
  endfunction

  task automatic ex(input logic [W-1:0] m, input logic [4:0] o);
    seq_q.push_back(m | RUN | opf(o));
  endtask

  // Model: full per-cycle expectation for one instruction, fetch included
  task automatic build_seq(input logic [31:0] ir, input logic cf);
    logic [4:0] op, aop;
    op  = ir[31:27];
    aop = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd10 : (op == 5'd14) ? 5'd11 : op;
    seq_q.delete();
    seq_q.push_back(RUN | PC_O | MAR_E | INCPC | Z_E);
    seq_q.push_back(RUN | ZLO_O | PC_E | READ | MDR_E);
    seq_q.push_back(RUN | MDR_O | IR_E);
    case (op)
      5'd0, 5'd1, 5'd2: begin
        ex(GRB | BA_O | Y_E, op);
        ex(C_O | Z_E, 5'd3);
        if (op == 5'd1) ex(ZLO_O | GRA | R_IN, op);
        else ex(ZLO_O | MAR_E, op);
        if (op == 5'd0) begin
          ex(READ | MDR_E, op);
          ex(MDR_O | GRA | R_IN, op);
        end else if (op == 5'd2) begin
          ex(GRA | R_O | MDR_E, op);
          ex(RAMW, op);
        end
      end
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
      5'd12, 5'd13, 5'd14: begin
        ex(GRB | R_O | Y_E, aop);
        ex((op >= 5'd12) ? (C_O | Z_E) : (GRC | R_O | Z_E), aop);
        ex(ZLO_O | GRA | R_IN, aop);
      end
`ifdef CTRL_MULDIV_EN
      5'd15, 5'd16: begin
        ex(GRA | R_O | Y_E, op);
        ex(GRB | R_O | Z_E, op);
        ex(ZLO_O | LO_E, op);
        ex(ZHI_O | HI_E, op);
      end
`endif
      5'd17, 5'd18: begin
        ex(GRB | R_O | Z_E, op);
        ex(ZLO_O | GRA | R_IN, op);
      end
      5'd19: begin
        ex(GRA | R_O | CON_IN, op);
        ex(PC_O | Y_E, op);
        ex(C_O | Z_E, 5'd3);
        ex(ZLO_O | (cf ? PC_E : '0), op);
      end
      5'd20: ex(GRA | R_O | PC_E, op);
      5'd21: begin
        ex(PC_O | GRB | R_IN, op);
        ex(GRA | R_O | PC_E, op);
      end
      5'd22: ex(INP_O | GRA | R_IN, op);
      5'd23: ex(GRA | R_O | OUTP_E, op);
      5'd24: ex(HI_O | GRA | R_IN, op);
      5'd25: ex(LO_O | GRA | R_IN, op);
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: entered 1 ns into a cycle whose expectation is not yet queued
  task automatic run_instr(input logic [31:0] ir, input logic cf, input int cut);
    int n;
    bus.IR     = ir;
    bus.con_ff = cf;
    build_seq(ir, cf);
    n = (cut > 0) ? cut : seq_q.size();
    for (int k = 0; k < n; k++) exp_q.push_back(seq_q[k]);
    if (cut > 0) repeat (n - 1) @(posedge clk);
    else repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_zero(input int n);
    repeat (n) begin
      exp_q.push_back('0);
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_clr(input int n);
    clr = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      exp_q.push_back('0);
    end
    clr = 1'b0;
    @(posedge clk); #1;
  endtask

  // compare process: every cycle with a queued expectation
  always @(negedge clk) begin
    logic [W-1:0] e;
    cyc++;
    if (bus.IncPC === 1'b1) t0_q.push_back(cyc);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (w_act !== e) begin
        errors++;
        $display("FAIL strobes cyc=%0d state=%0d: got %h, expected %h",
                 cyc, bus.dbg_state, w_act, e);
      end
    end
  end

  initial begin
    #50000;
    errors++;
    checks++;
    $display("FAIL watchdog: still running at 50000 ns, required to finish earlier");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int d;
    clr = 1'b1;
    bus.IR = '0;
    bus.con_ff = 1'b0;

    // pin the model with hand-computed vectors
    build_seq(32'h19890000, 1'b0);
    check("model_fetch_t0", 64'(seq_q[0]), 64'h0_0900_9001);
    check("model_add_t4", 64'(seq_q[4]), 64'h0_3880_8200);
    check("model_add_len", 64'(seq_q.size()), 64'd6);
    build_seq(32'h98000000, 1'b0);
    check("model_br_t6", 64'(seq_q[6]), 64'h1_3800_0002);
    build_seq(32'h11000000, 1'b0);
    check("model_st_t7", 64'(seq_q[7]), 64'h0_2C00_0000);

    apply_clr(2);
    for (int i = 0; i < N; i++) run_instr(t_ir[i], t_cf[i], 0);

    // halt holds for 10 cycles, then clr restarts fetch
    run_instr(32'hD8000000, 1'b0, 0);
    idle_zero(9);
    check("halt_run", 64'(bus.run), 64'd0);
    exp_q.push_back('0);
    apply_clr(1);

    // clr in ld T5 -> RESET, then T0 and a full add
    run_instr(32'h00800000, 1'b0, 6);
    apply_clr(1);
    run_instr(32'h19890000, 1'b0, 0);

    @(negedge clk); #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < N; i++) begin
      d = (t0_q.size() > i + 1) ? (t0_q[i + 1] - t0_q[i]) : -1;
      check($sformatf("t0_spacing_%0d", i), 64'(d), 64'(t_len[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
